// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - shared types and address decode for the 68000 bus-cycle controller
package m68k_bus_pkg;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_DEV,
        REG_UNMAPPED
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP,
        ST_ACK,
        ST_VPA,
        ST_BERR
    } state_e;

    localparam logic [2:0] FC_IACK = 3'b111;

    // a_hi carries A19..A15; DEV takes priority over the wider UNMAPPED hole.
    function automatic region_e decode_region(input logic [4:0] a_hi);
        if (a_hi[4])
            return REG_RAM;
        else if (a_hi == 5'b01111)
            return REG_DEV;
        else if (a_hi[4:2] == 3'b011)
            return REG_UNMAPPED;
        else
            return REG_ROM;
    endfunction

endpackage

// File: rtl/m68k_bus_ctrl_btn_debounce.sv
// rtl/m68k_bus_ctrl_btn_debounce.sv - step-button synchroniser, slow sampler and rise detector
// Ports:
//   clk_i    in  clock
//   reset_i  in  async active-high reset
//   btn_i    in  raw push button, active-high
//   rise_o   out one-clock pulse on each debounced press
module btn_debounce #(
    parameter int DEB_BITS = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic rise_o
);

    logic [DEB_BITS-1:0] div_q;
    logic                btn_s1_q, btn_s2_q;
    logic                samp0_q, samp1_q;
    logic                level_q;
    logic                rise_q;
    logic                tick;
    logic                agree;

    assign tick  = &div_q;
    // The level only moves once two consecutive slow samples agree.
    assign agree = (samp0_q == samp1_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q    <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            samp0_q  <= 1'b0;
            samp1_q  <= 1'b0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            div_q    <= div_q + {{(DEB_BITS-1){1'b0}}, 1'b1};
            btn_s1_q <= btn_i;
            btn_s2_q <= btn_s1_q;
            if (tick) begin
                samp0_q <= btn_s2_q;
                samp1_q <= samp0_q;
            end
            if (agree)
                level_q <= samp0_q;
            rise_q <= agree & samp0_q & ~level_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/m68k_bus_ctrl.sv
// rtl/m68k_bus_ctrl.sv - 68000 bus-cycle controller: decode, wait states, VPA/BERR, single-step
// Ports:
//   clk_i, reset_i             clock, async active-high reset
//   addr_i[7:0]                A19..A12
//   as_n_i, ds_n_i             address/data strobes, active-low, asynchronous
//   rw_i, fc_i[2:0]            read/write, function code
//   step_mode_i, step_btn_i    single-step enable, raw step button
//   dtack_n_o, vpa_n_o, berr_n_o   registered cycle terminations, active-low
//   ceram_n_o, cerom_n_o, dev_sel_o  combinational chip selects
//   busy_o                     controller not idle
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int ROM_WS   = 2,
    parameter int RAM_WS   = 0,
    parameter int DEV_WS   = 3,
    parameter int TIMEOUT  = 64,
    parameter int DEB_BITS = 15
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] addr_i,
    input  logic       as_n_i,
    input  logic       ds_n_i,
    input  logic       rw_i,
    input  logic [2:0] fc_i,
    input  logic       step_mode_i,
    input  logic       step_btn_i,
    output logic       dtack_n_o,
    output logic       vpa_n_o,
    output logic       berr_n_o,
    output logic       ceram_n_o,
    output logic       cerom_n_o,
    output logic       dev_sel_o,
    output logic       busy_o
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] ws_q, ws_d;
    logic [15:0] to_q, to_d;
    logic        step_lat_q, step_lat_d;
    logic        as_s1_q, as_s2_q, as_prev_q;
    logic        dtack_n_q, vpa_n_q, berr_n_q, busy_q;
    logic        step_pulse;
    logic        iack;
    logic        as_fall;
    region_e     region;
    logic [15:0] ws_sel;

    // Data strobe, direction and A14..A12 play no part in cycle termination.
    logic unused_inputs;
    assign unused_inputs = ^{ds_n_i, rw_i, addr_i[2:0]};

    btn_debounce #(.DEB_BITS(DEB_BITS)) u_btn (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .btn_i  (step_btn_i),
        .rise_o (step_pulse)
    );

    assign iack    = (fc_i == FC_IACK);
    assign region  = decode_region(addr_i[7:3]);
    assign as_fall = as_prev_q & ~as_s2_q;

    always_comb begin
        ws_sel = 16'd0;
        case (region)
            REG_ROM: ws_sel = 16'(ROM_WS);
            REG_RAM: ws_sel = 16'(RAM_WS);
            REG_DEV: ws_sel = 16'(DEV_WS);
            default: ws_sel = 16'd0;
        endcase
    end

    // Chip selects follow the raw strobe so memory sees the cycle as early as possible.
    assign ceram_n_o = ~(~as_n_i & addr_i[7] & ~iack);
    assign cerom_n_o = ~((region == REG_ROM) & ~as_n_i & ~iack);
    assign dev_sel_o = (region == REG_DEV) & ~as_n_i & ~iack;

    always_comb begin
        state_d    = state_q;
        ws_d       = ws_q;
        to_d       = to_q;
        step_lat_d = step_lat_q;
        case (state_q)
            ST_IDLE: begin
                step_lat_d = step_mode_i;
                if (as_fall) begin
                    if (iack)
                        state_d = ST_VPA;
                    else if (region == REG_UNMAPPED)
                        state_d = ST_BERR;
                    else if (ws_sel == 16'd0)
                        // Zero wait states skip WAIT so DTACK lands one clock after sync.
                        state_d = step_mode_i ? ST_STEP : ST_ACK;
                    else begin
                        state_d = ST_WAIT;
                        ws_d    = ws_sel - 16'd1;
                        to_d    = 16'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (as_s2_q)
                    state_d = ST_IDLE;
                else if (to_q == TO_LAST)
                    state_d = ST_BERR;
                else if (ws_q == 16'd0)
                    state_d = step_lat_q ? ST_STEP : ST_ACK;
                else begin
                    ws_d = ws_q - 16'd1;
                    to_d = to_q + 16'd1;
                end
            end
            ST_STEP: begin
                if (as_s2_q)
                    state_d = ST_IDLE;
                else if (step_pulse)
                    state_d = ST_ACK;
            end
            ST_ACK, ST_VPA, ST_BERR: begin
                if (as_s2_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            ws_q       <= 16'd0;
            to_q       <= 16'd0;
            step_lat_q <= 1'b0;
            as_s1_q    <= 1'b1;
            as_s2_q    <= 1'b1;
            as_prev_q  <= 1'b1;
            dtack_n_q  <= 1'b1;
            vpa_n_q    <= 1'b1;
            berr_n_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ws_q       <= ws_d;
            to_q       <= to_d;
            step_lat_q <= step_lat_d;
            as_s1_q    <= as_n_i;
            as_s2_q    <= as_s1_q;
            as_prev_q  <= as_s2_q;
            dtack_n_q  <= (state_d != ST_ACK);
            vpa_n_q    <= (state_d != ST_VPA);
            berr_n_q   <= (state_d != ST_BERR);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign dtack_n_o = dtack_n_q;
    assign vpa_n_o   = vpa_n_q;
    assign berr_n_o  = berr_n_q;
    assign busy_o    = busy_q;

endmodule
